saes_iter_core: RTL and testbench
=================================

// Module: saes_iter_core
// PURPOSE
//  Iterative Simplified-AES engine: one round per clock, encrypt or decrypt per transaction, round count parametrised.
//  Sits between a valid/ready 16-bit block source and sink; successor to the combinational 2-round decrypt-only datapath.
//  Key expansion runs on-chip per transaction; round keys are held in registers so decrypt can walk them in reverse.
// PARAMETERS
//  NUM_ROUNDS  2  S-AES rounds, legal 1..8; 2 = standard S-AES. RCON(i) = {x^(i+2) mod (x^4+x+1), 4'h0}
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   block+key+mode offered
//  in_ready   out  1   engine idle, accepts offer
//  in_mode    in   1   0 = encrypt, 1 = decrypt
//  in_key     in   16  cipher key (K0)
//  in_data    in   16  plaintext (enc) / ciphertext (dec)
//  out_valid  out  1   result available
//  out_ready  in   1   sink accepts result
//  out_data   out  16  ciphertext (enc) / plaintext (dec)
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, all key/state regs 0. Asserting rst_n low mid-op aborts at once, no output.
//  FSM IDLE -> KEYEXP -> ROUND -> DONE -> IDLE.
//  IDLE: in_ready=1. Handshake in_valid&&in_ready latches mode, key, data, then KEYEXP. rk[0]=key.
//    st = data^key for enc, st = data for dec.
//  KEYEXP: NUM_ROUNDS cycles, cycle i computes rk[i] from rk[i-1] using g() with RCON(i). Counter runs 1..NUM_ROUNDS.
//  ROUND: NUM_ROUNDS cycles, counter r.
//    enc, r=1..N: st = SR(NS(st)), MC if r<N, then ^rk[r].
//    dec, r=N..1: st = INS(ISR(IMC if r<N (st^rk[r]))); on r=1 also ^rk[0].
//  DONE: out_valid=1, out_data=st. Hold stable while !out_ready. out_valid&&out_ready -> IDLE, in_ready high next cycle.
//  Latency: accept edge -> out_valid high after 2*NUM_ROUNDS+1 cycles (5 for default); throughput one block per 2N+2 cycles min.
//  in_ready=0 outside IDLE; in_valid ignored there. out_ready ignored outside DONE.
//  Arithmetic: GF(2^4) mod x^4+x+1; MC = [[1,4],[4,1]], IMC = [[9,2],[2,9]]. SR/ISR swap low nibbles of the two bytes.
//  Nibble order per byte: [15:12][11:8] = column 0, [7:4][3:0] = column 1.
// CONFIGURATION
//  SAES_CBC_EN defined: adds ports iv_load (in,1) and iv (in,16), plus a 16-bit chain register, reset 0.
//    iv_load high in IDLE (no accept same cycle) sets chain=iv; iv_load outside IDLE is ignored.
//    If iv_load and an accept coincide, the accept wins and iv_load is dropped.
//    enc: data^chain before ARK0; at DONE entry, chain=ciphertext.
//    dec: result^chain on output; at DONE entry, chain=latched ciphertext input.
//  SAES_CBC_EN undefined: ECB only, ports and chain absent, behaviour as above.
// STRUCTURE
//  Package saes_pkg: SBOX/INV_SBOX nibble tables, gf16_mul function, rcon(i) function, FSM state enum, MODE_ENC/MODE_DEC constants.
//  Sub-module saes_round (combinational): inputs st, rk, mode, last, first; output next st.
//    Covers NS/SR/MC/ARK in both directions.
//  Top module holds the FSM, counters, rk array [0:NUM_ROUNDS], chain register and the key-expansion g().
// TESTING
//  enc key 16'h4AF5, data 16'hD728 -> out_data 16'h24EC; out_valid exactly 5 cycles after accept.
//  dec key 16'h4AF5, data 16'h24EC -> 16'hD728. dec key 16'hA73B, data 16'h0738 -> 16'h6F6B.
//  out_ready held low 10 cycles -> out_data/out_valid stable, in_ready=0. Then release -> in_ready=1 next cycle.
//    Second block accepted back-to-back.
//  rst_n low during ROUND -> out_valid=0, in_ready=1 immediately. Fresh block afterwards gives the correct result.
//  NUM_ROUNDS=1,3,4: 256 random key/data pairs, enc then dec round-trip -> original data; latency 2N+1.
//  SAES_CBC_EN: iv=16'h1234, enc 3 blocks, then reload iv and dec the 3 ciphertexts -> original plaintexts.
//    First enc equals ECB enc of data^16'h1234.

Source files
------------

// File: rtl/saes_pkg.sv
// Shared S-AES definitions: nibble S-boxes, GF(2^4) multiply, key-schedule round
// constants, FSM state encoding and mode constants.
package saes_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYEXP,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [3:0] SBOX [0:15] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  localparam logic [3:0] INV_SBOX [0:15] = '{
    4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
    4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
  };

  // Multiply in GF(2^4) modulo x^4 + x + 1.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // RCON(i) = {x^(i+2) mod (x^4+x+1), 4'h0}; i is always an elaboration constant.
  function automatic logic [7:0] rcon(input int unsigned i);
    logic [3:0] v;
    v = 4'h1;
    for (int unsigned j = 0; j < i + 2; j++) v = gf16_mul(v, 4'h2);
    return {v, 4'h0};
  endfunction

endpackage

// File: rtl/saes_round.sv
// One combinational S-AES round in either direction: NS/SR/MC/ARK for encrypt,
// ARK/IMC/ISR/INS (+ final ARK with rk0) for decrypt.
module saes_round
  import saes_pkg::*;
(
  input  logic [15:0] st,
  input  logic [15:0] rk,
  input  logic [15:0] rk0,
  input  logic        mode,
  input  logic        last,
  input  logic        first,
  output logic [15:0] nxt
);

  // Column-wise [[a,b],[b,a]] product; columns are [15:8] and [7:0].
  function automatic logic [15:0] mix(input logic [15:0] s, input logic [3:0] a, input logic [3:0] b);
    return {gf16_mul(a, s[15:12]) ^ gf16_mul(b, s[11:8]),
            gf16_mul(b, s[15:12]) ^ gf16_mul(a, s[11:8]),
            gf16_mul(a, s[7:4])   ^ gf16_mul(b, s[3:0]),
            gf16_mul(b, s[7:4])   ^ gf16_mul(a, s[3:0])};
  endfunction

  function automatic logic [15:0] swap_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  logic [15:0] enc_sr;
  logic [15:0] enc_mc;
  logic [15:0] dec_ark;
  logic [15:0] dec_imc;
  logic [15:0] dec_isr;
  logic [15:0] dec_ins;

  always_comb begin
    enc_sr  = swap_rows({SBOX[st[15:12]], SBOX[st[11:8]], SBOX[st[7:4]], SBOX[st[3:0]]});
    enc_mc  = last ? enc_sr : mix(enc_sr, 4'h1, 4'h4);
    dec_ark = st ^ rk;
    dec_imc = last ? dec_ark : mix(dec_ark, 4'h9, 4'h2);
    dec_isr = swap_rows(dec_imc);
    dec_ins = {INV_SBOX[dec_isr[15:12]], INV_SBOX[dec_isr[11:8]],
               INV_SBOX[dec_isr[7:4]],   INV_SBOX[dec_isr[3:0]]};
    if (mode == MODE_ENC) nxt = enc_mc ^ rk;
    else                  nxt = first ? (dec_ins ^ rk0) : dec_ins;
  end

endmodule

// File: rtl/saes_iter_core.sv
// Iterative S-AES engine, one round per clock, on-chip key expansion per block.
// Optional CBC chaining (iv_load/iv ports, chain register) when SAES_CBC_EN is defined.
module saes_iter_core
  import saes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_key,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
`ifdef SAES_CBC_EN
  ,
  input  logic        iv_load,
  input  logic [15:0] iv
`endif
);

  localparam int unsigned CW = $clog2(NUM_ROUNDS + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mode;
  logic [15:0]   st;
  logic [15:0]   rk [0:NUM_ROUNDS];
  logic [15:0]   rk_cur;
  logic [15:0]   rk_prev;
  logic [15:0]   key_next;
  logic [15:0]   round_out;
  logic [15:0]   chain;
  logic [7:0]    rc;
  logic [7:0]    g_word;
  logic          accept;
  logic          last;
  logic          first;
  logic          rounds_done;

  assign accept      = (state == S_IDLE) && in_valid;
  assign last        = (cnt == CW'(NUM_ROUNDS));
  assign first       = (cnt == CW'(1));
  assign rounds_done = (mode == MODE_ENC) ? last : first;

  // The counter doubles as key-schedule step and round index.
  always_comb begin
    rk_cur  = rk[0];
    rk_prev = rk[0];
    rc      = '0;
    for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
      if (cnt == CW'(i)) begin
        rk_cur  = rk[i];
        rk_prev = rk[i-1];
        rc      = rcon(i);
      end
    end
    g_word   = {SBOX[rk_prev[3:0]], SBOX[rk_prev[7:4]]} ^ rc;
    key_next = {rk_prev[15:8] ^ g_word, rk_prev[15:8] ^ g_word ^ rk_prev[7:0]};
  end

  saes_round u_round (
    .st    (st),
    .rk    (rk_cur),
    .rk0   (rk[0]),
    .mode  (mode),
    .last  (last),
    .first (first),
    .nxt   (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      mode      <= MODE_ENC;
      cnt       <= '0;
      st        <= '0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            mode     <= in_mode;
            rk[0]    <= in_key;
            st       <= (in_mode == MODE_ENC) ? (in_data ^ chain ^ in_key) : in_data;
            cnt      <= CW'(1);
            in_ready <= 1'b0;
            state    <= S_KEYEXP;
          end
        end
        S_KEYEXP: begin
          for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
            if (cnt == CW'(i)) rk[i] <= key_next;
          end
          if (last) begin
            state <= S_ROUND;
            cnt   <= (mode == MODE_ENC) ? CW'(1) : CW'(NUM_ROUNDS);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ROUND: begin
          st <= round_out;
          if (rounds_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= (mode == MODE_ENC) ? round_out : (round_out ^ chain);
          end else if (mode == MODE_ENC) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SAES_CBC_EN
  logic [15:0] ct_in;

  // Accept takes priority over a coincident iv_load; the chain advances as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      ct_in <= '0;
    end else if (accept) begin
      ct_in <= in_data;
    end else if (state == S_IDLE && iv_load) begin
      chain <= iv;
    end else if (state == S_ROUND && rounds_done) begin
      chain <= (mode == MODE_ENC) ? round_out : ct_in;
    end
  end
`else
  assign chain = '0;
`endif

endmodule

// File: tb/tb_saes_iter_core.sv
// Directed bench for saes_iter_core: instances with NUM_ROUNDS = 2, 1, 3, 4;
// known-answer vectors on the default instance, round trips on the others.
module tb_saes_iter_core;

  localparam int unsigned NR [0:3] = '{2, 1, 3, 4};
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [0:3];
  logic        in_ready  [0:3];
  logic        in_mode   [0:3];
  logic [15:0] in_key    [0:3];
  logic [15:0] in_data   [0:3];
  logic        out_valid [0:3];
  logic        out_ready [0:3];
  logic [15:0] out_data  [0:3];
`ifdef SAES_CBC_EN
  logic        iv_load   [0:3];
  logic [15:0] iv        [0:3];
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    saes_iter_core #(.NUM_ROUNDS(NR[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_mode   (in_mode[g]),
      .in_key    (in_key[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
`ifdef SAES_CBC_EN
      ,
      .iv_load   (iv_load[g]),
      .iv        (iv[g])
`endif
    );
  end

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; out_ready must be high.
  // lat counts cycles after the accept edge until out_valid is seen (cycle 1 = first after it).
  task automatic run_block(input int k, input logic m, input logic [15:0] key, input logic [15:0] data,
                           output logic [15:0] res, output int lat);
    int n;
    in_mode[k]  = m;
    in_key[k]   = key;
    in_data[k]  = data;
    in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready[k]), 32'd1);
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid[k] && lat < 100);
    res = out_data[k];
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] ct;
    logic [15:0] key;
    logic [15:0] pt;
    int          lat;
    int          n;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_mode[i]   = ENC;
      in_key[i]    = '0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
`ifdef SAES_CBC_EN
      iv_load[i]   = 1'b0;
      iv[i]        = '0;
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready",  32'(in_ready[0]),  32'd1);
    chk("reset_out_valid", 32'(out_valid[0]), 32'd0);
    chk("reset_out_data",  32'(out_data[0]),  32'h0);

`ifndef SAES_CBC_EN
    run_block(0, ENC, 16'h4AF5, 16'hD728, res, lat);
    chk("enc_4af5", 32'(res), 32'h24EC);
    chk("enc_lat",  32'(lat), 32'd5);
    run_block(0, DEC, 16'h4AF5, 16'h24EC, res, lat);
    chk("dec_4af5", 32'(res), 32'hD728);
    chk("dec_lat",  32'(lat), 32'd5);
    run_block(0, DEC, 16'hA73B, 16'h0738, res, lat);
    chk("dec_a73b", 32'(res), 32'h6F6B);
    run_block(0, ENC, 16'hA73B, 16'h6F6B, res, lat);
    chk("enc_a73b", 32'(res), 32'h0738);

    // Backpressure: result must hold while a new offer waits outside IDLE.
    out_ready[0] = 1'b0;
    in_mode[0]   = ENC;
    in_key[0]    = 16'h4AF5;
    in_data[0]   = 16'hD728;
    in_valid[0]  = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[0] && n < 100);
    chk("bp_lat", 32'(n), 32'd5);
    in_mode[0]  = DEC;
    in_key[0]   = 16'h4AF5;
    in_data[0]  = 16'h24EC;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_data",  32'(out_data[0]),  32'h24EC);
      chk("bp_in_ready",  32'(in_ready[0]),  32'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready",  32'(in_ready[0]),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
    run_block(0, DEC, 16'h4AF5, 16'h24EC, res, lat);
    chk("b2b_data", 32'(res), 32'hD728);
    chk("b2b_lat",  32'(lat), 32'd5);

    // Reset in the middle of ROUND aborts with no output.
    in_mode[0]  = ENC;
    in_key[0]   = 16'hA73B;
    in_data[0]  = 16'h6F6B;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_in_ready", 32'(in_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_in_ready",  32'(in_ready[0]),  32'd1);
    chk("abort_out_data",  32'(out_data[0]),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_output", 32'(out_valid[0]), 32'd0);
    run_block(0, ENC, 16'hA73B, 16'h6F6B, res, lat);
    chk("post_abort_data", 32'(res), 32'h0738);
    chk("post_abort_lat",  32'(lat), 32'd5);

    // Other round counts: encrypt then decrypt must return the plaintext.
    for (int k = 1; k < 4; k++) begin
      for (int t = 0; t < 256; t++) begin
        key = 16'($urandom);
        pt  = 16'($urandom);
        run_block(k, ENC, key, pt, ct, lat);
        chk("rt_enc_lat", 32'(lat), 32'(2 * NR[k] + 1));
        run_block(k, DEC, key, ct, res, lat);
        chk("rt_data",    32'(res), 32'(pt));
        chk("rt_dec_lat", 32'(lat), 32'(2 * NR[k] + 1));
      end
    end
`else
    // Plaintexts chosen so every chained input is a known S-AES vector.
    iv_load[0] = 1'b1;
    iv[0]      = 16'h1234;
    @(negedge clk);
    iv_load[0] = 1'b0;
    run_block(0, ENC, 16'h4AF5, 16'hC51C, res, lat);
    chk("cbc_enc1", 32'(res), 32'h24EC);
    chk("cbc_lat",  32'(lat), 32'd5);
    run_block(0, ENC, 16'hA73B, 16'h4B87, res, lat);
    chk("cbc_enc2", 32'(res), 32'h0738);
    run_block(0, ENC, 16'h4AF5, 16'hD010, res, lat);
    chk("cbc_enc3", 32'(res), 32'h24EC);
    iv_load[0] = 1'b1;
    iv[0]      = 16'h1234;
    @(negedge clk);
    iv_load[0] = 1'b0;
    run_block(0, DEC, 16'h4AF5, 16'h24EC, res, lat);
    chk("cbc_dec1", 32'(res), 32'hC51C);
    run_block(0, DEC, 16'hA73B, 16'h0738, res, lat);
    chk("cbc_dec2", 32'(res), 32'h4B87);
    run_block(0, DEC, 16'h4AF5, 16'h24EC, res, lat);
    chk("cbc_dec3", 32'(res), 32'hD010);
    chk("cbc_lat_dec", 32'(lat), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
